// File: rtl/hazard_ctrl_unit.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_unit
//
// Hazard and forwarding control for a five-stage MIPS-style pipeline.
// Combines load-use detection, EX/MEM and MEM/WB operand forwarding and
// store-data forwarding. A small FSM inserts LU_STALL bubbles per load-use
// hazard. The whole pipeline is frozen while either L1 cache reports a miss.
//
// Optional feature macro: HAZ_PERF_CNT_EN
//   defined   : saturating performance counters for stall and freeze cycles
//   undefined : counters are tied to zero and no counter flops exist
//
// Parameters
//   AW        register-address width
//   LU_STALL  bubbles per load-use hazard (1..7)
//   CNT_W     performance counter width
//
// Ports
//   clk, rst                  clock (rising edge), async active-high reset
//   id_rs, id_rt              ID-stage source registers
//   id_use_rs, id_use_rt      ID instruction really reads rs / rt
//   ex_mem_read               EX instruction is a load
//   ex_rs, ex_rt              EX sources (ex_rt is also the load target)
//   mem_reg_write             MEM instruction writes the register file
//   mem_mem_read              MEM instruction is a load
//   mem_mem_write             MEM instruction is a store
//   mem_rd, mem_rt            MEM destination / store-data source
//   wb_reg_write, wb_rd       WB write enable / destination
//   icache_stall              instruction-cache miss in progress
//   dcache_stall              data-cache miss in progress
//   pc_write, if_id_write     PC / IF-ID update enables
//   id_ex_bubble              zero the ID/EX control word
//   pipe_freeze               hold ID/EX, EX/MEM and MEM/WB
//   fwd_a, fwd_b              00 regfile, 01 MEM/WB, 10 EX/MEM
//   fwd_store_data            replace MEM store data with WB result
//   lu_stall_cnt, freeze_cnt  performance counters
// ---------------------------------------------------------------------------
module hazard_ctrl_unit #(
    parameter int AW       = 5,
    parameter int LU_STALL = 1,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    id_rs,
    input  logic [AW-1:0]    id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             ex_mem_read,
    input  logic [AW-1:0]    ex_rs,
    input  logic [AW-1:0]    ex_rt,
    input  logic             mem_reg_write,
    input  logic             mem_mem_read,
    input  logic             mem_mem_write,
    input  logic [AW-1:0]    mem_rd,
    input  logic [AW-1:0]    mem_rt,
    input  logic             wb_reg_write,
    input  logic [AW-1:0]    wb_rd,
    input  logic             icache_stall,
    input  logic             dcache_stall,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             pipe_freeze,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             fwd_store_data,
    output logic [CNT_W-1:0] lu_stall_cnt,
    output logic [CNT_W-1:0] freeze_cnt
);

    typedef enum logic {IDLE, LU_WAIT} state_t;

    localparam logic [2:0] LU_RELOAD = 3'(LU_STALL - 1);

    state_t     state;
    logic [2:0] cnt;
    logic       freeze;
    logic       hazard;
    logic       stall;

    // Forwarding source for one EX operand; EX/MEM beats MEM/WB, and a load
    // sitting in MEM has no result yet so it is never an EX/MEM source.
    function automatic logic [1:0] fwd_sel(input logic [AW-1:0] ex_x);
        if (mem_reg_write && !mem_mem_read && (mem_rd != '0) && (mem_rd == ex_x))
            return 2'b10;
        else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_x))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        freeze = icache_stall | dcache_stall;
        hazard = ex_mem_read && (ex_rt != '0) &&
                 ((id_use_rs && (ex_rt == id_rs)) || (id_use_rt && (ex_rt == id_rt)));
        // While in LU_WAIT the stall continues regardless of the current hazard.
        stall  = !freeze && ((state == LU_WAIT) || hazard);
    end

    assign pipe_freeze    = freeze;
    assign pc_write       = !freeze && !stall;
    assign if_id_write    = !freeze && !stall;
    assign id_ex_bubble   = stall;
    assign fwd_a          = fwd_sel(ex_rs);
    assign fwd_b          = fwd_sel(ex_rt);
    assign fwd_store_data = mem_mem_write && wb_reg_write && (wb_rd != '0) && (wb_rd == mem_rt);

    // Bubble sequencer; a frozen cycle holds state and cnt, which stretches
    // the stall window one-for-one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else if (!freeze) begin
            case (state)
                IDLE: begin
                    if (hazard && (LU_STALL > 1)) begin
                        state <= LU_WAIT;
                        cnt   <= LU_RELOAD;
                    end
                end
                LU_WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1)
                        state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 3'd0;
                end
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] lu_cnt_q;
    logic [CNT_W-1:0] frz_cnt_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lu_cnt_q  <= '0;
            frz_cnt_q <= '0;
        end else begin
            if (stall)
                lu_cnt_q <= sat_inc(lu_cnt_q);
            if (freeze)
                frz_cnt_q <= sat_inc(frz_cnt_q);
        end
    end

    assign lu_stall_cnt = lu_cnt_q;
    assign freeze_cnt   = frz_cnt_q;
`else
    assign lu_stall_cnt = '0;
    assign freeze_cnt   = '0;
`endif

endmodule
